// File: rtl/ifetch_pkg.sv
// Shared encodings for the instruction fetch stage: FSM states, branch codes,
// default reset PC and the branch-offset helper.
package ifetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned CB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [CB_W-1:0] CB_NOJUMP = 4'd0;
    localparam logic [CB_W-1:0] CB_BR_BEQ = 4'd1;
    localparam logic [CB_W-1:0] CB_BR_J   = 4'd2;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Word offset of a beq immediate, sign-extended and scaled to bytes.
    function automatic logic [XLEN-1:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_npc.sv
// Next-PC computation: sequential, beq target or j target. Purely combinational
// so a pipelined core can reuse it unchanged.
module ifetch_npc
    import ifetch_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] inst,
    input  logic [CB_W-1:0] cb,
    input  logic            zero,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc
);

    always_comb begin
        pc_plus4 = pc + XLEN'(4);
        next_pc  = pc_plus4;
        case (cb)
            CB_BR_J:   next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
            CB_BR_BEQ: if (zero) next_pc = pc_plus4 + br_offset(inst[15:0]);
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, request/response handshake with
// instruction memory, and one held instruction presented to decode.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst,
    output logic            inst_valid,
    input  logic            inst_ready,
    input  logic [CB_W-1:0] cb,
    input  logic            zero,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] icount
);

    localparam logic [XLEN-1:0] PC_INIT = {RESET_PC[XLEN-1:2], 2'b00};

    state_t          state_q;
    state_t          state_d;
    logic            req_d;
    logic            valid_d;
    logic            inst_load;
    logic            retire;
    logic [XLEN-1:0] next_pc;

    ifetch_npc u_npc (
        .pc       (pc),
        .inst     (inst),
        .cb       (cb),
        .zero     (zero),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    assign imem_addr = pc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (imem_gnt)    state_d = ST_WAIT;
            ST_WAIT:  if (imem_rvalid) state_d = ST_HOLD;
            ST_HOLD:  if (inst_ready)  state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output/control decode; handshake outputs are registered from state_d
    always_comb begin
        req_d     = 1'b0;
        valid_d   = 1'b0;
        inst_load = 1'b0;
        retire    = 1'b0;
        if (state_d == ST_FETCH) req_d   = 1'b1;
        if (state_d == ST_HOLD)  valid_d = 1'b1;
        if (state_q == ST_WAIT && imem_rvalid) inst_load = 1'b1;
        if (state_q == ST_HOLD && inst_ready)  retire    = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
        end else begin
            imem_req   <= req_d;
            inst_valid <= valid_d;
        end
    end

    // Datapath registers: held instruction, PC and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst   <= '0;
            pc     <= PC_INIT;
            icount <= '0;
        end else begin
            if (inst_load) begin
                inst <= imem_rdata;
            end
            if (retire) begin
                pc     <= {next_pc[XLEN-1:2], 2'b00};
                icount <= icount + XLEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Randomized self-checking bench for ifetch against a transaction-level model
// of PC sequencing, instruction hand-off and the retire counter.
module tb_ifetch;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, pc, pc_plus4, icount;
    logic        imem_gnt, imem_rvalid, inst_ready, zero;
    logic [31:0] imem_rdata;
    logic [3:0]  cb;

    logic        w_imem_req, w_inst_valid;
    logic [31:0] w_imem_addr, w_inst, w_pc, w_pc_plus4, w_icount;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_icount;

    always #5 clk = ~clk;

    ifetch u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .cb(cb), .zero(zero), .pc(pc), .pc_plus4(pc_plus4), .icount(icount)
    );

    // Second copy at the top of the address space, sharing all stimulus
    ifetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(w_inst), .inst_valid(w_inst_valid), .inst_ready(inst_ready),
        .cb(cb), .zero(zero), .pc(w_pc), .pc_plus4(w_pc_plus4), .icount(w_icount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [31:0] word,
                                                input logic [3:0] code, input logic z);
        logic [31:0] seq;
        logic signed [31:0] off;
        seq = cur + 32'd4;
        off = 32'(signed'(word[15:0]));
        if (code == CB_BR_J)
            return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
        if (code == CB_BR_BEQ && z)
            return seq + 32'(off * 4);
        return seq;
    endfunction

    // One instruction: gnt after gd cycles, rvalid after rd more, retire after sd stall cycles
    task automatic run_instr(input int gd, input int rd, input int sd, input logic [31:0] data,
                             input logic [3:0] code, input logic z);
        int guard;
        guard = 0;
        while (!imem_req && guard < 20) begin
            step();
            guard++;
        end
        check("req_seen", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, m_pc);
        repeat (gd) begin
            imem_rvalid = 1'($urandom);
            imem_rdata  = $urandom;
            step();
            check("req_held", 32'(imem_req), 32'd1);
            check("addr_held", imem_addr, m_pc);
        end
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        step();
        imem_gnt = 1'b0;
        check("req_drop", 32'(imem_req), 32'd0);
        repeat (rd) begin
            imem_rdata = $urandom;
            inst_ready = 1'($urandom);
            step();
            check("wait_no_valid", 32'(inst_valid), 32'd0);
            check("wait_no_req", 32'(imem_req), 32'd0);
        end
        inst_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        check("inst_valid", 32'(inst_valid), 32'd1);
        check("inst", inst, data);
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("icount_hold", icount, m_icount);
        repeat (sd) begin
            cb       = 4'($urandom);
            zero     = 1'($urandom);
            imem_gnt = 1'($urandom);
            step();
            check("stall_inst", inst, data);
            check("stall_pc", pc, m_pc);
            check("stall_icount", icount, m_icount);
            check("stall_no_req", 32'(imem_req), 32'd0);
            check("stall_valid", 32'(inst_valid), 32'd1);
        end
        imem_gnt   = 1'b0;
        inst_ready = 1'b1;
        cb         = code;
        zero       = z;
        step();
        inst_ready = 1'b0;
        cb         = 4'($urandom);
        zero       = 1'($urandom);
        m_pc       = ref_next_pc(m_pc, data, code, z);
        m_icount   = m_icount + 32'd1;
        check("retire_valid_drop", 32'(inst_valid), 32'd0);
        check("icount", icount, m_icount);
    endtask

    initial begin
        logic [31:0] t_data [10];
        logic [3:0]  t_cb   [10];
        logic        t_z    [10];
        logic [31:0] t_next [10];

        t_data = '{32'h0000_0020, 32'h0000_0020, 32'h0000_0020, 32'h0000_0020,
                   32'h1000_FFFF, 32'h1000_FFFF, 32'h0000_0020, 32'h0000_0020,
                   32'h0000_0020, 32'h0800_0C10};
        t_cb   = '{CB_NOJUMP, CB_NOJUMP, CB_NOJUMP, CB_NOJUMP, CB_BR_BEQ,
                   CB_BR_BEQ, CB_NOJUMP, CB_NOJUMP, CB_NOJUMP, CB_BR_J};
        t_z    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        t_next = '{32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3010,
                   32'h3014, 32'h3018, 32'h301C, 32'h3020, 32'h3040};

        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;
        cb          = CB_NOJUMP;
        zero        = 1'b0;
        m_pc        = 32'h0000_3000;
        m_icount    = '0;
        repeat (2) step();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_inst", inst, 32'd0);
        check("rst_icount", icount, 32'd0);
        rst_n = 1'b1;
        step();
        check("first_req", 32'(imem_req), 32'd1);
        check("wrap_first_addr", w_imem_addr, 32'hFFFF_FFFC);

        for (int i = 0; i < 10; i++) begin
            run_instr(0, 0, 0, t_data[i], t_cb[i], t_z[i]);
            check("plan_addr", imem_addr, t_next[i]);
            if (i == 0) check("wrap_next_addr", w_imem_addr, 32'h0000_0000);
            if (i == 2) check("icount_3", icount, 32'd3);
        end

        // gnt withheld, late rvalid, divu-style stall
        run_instr(5, 3, 4, 32'h0000_001B, CB_NOJUMP, 1'b0);
        check("after_stall_addr", imem_addr, 32'h3044);

        // reset in WAIT with a stale response arriving in IDLE
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_pc", pc, 32'h0000_3000);
        check("mid_rst_icount", icount, 32'd0);
        check("mid_rst_inst", inst, 32'd0);
        step();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("stale_not_captured", inst, 32'd0);
        check("stale_no_valid", 32'(inst_valid), 32'd0);
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", imem_addr, 32'h0000_3000);
        m_pc     = 32'h0000_3000;
        m_icount = '0;

        for (int i = 0; i < 40; i++) begin
            logic [3:0] code;
            case ($urandom_range(0, 3))
                0:       code = CB_NOJUMP;
                1:       code = CB_BR_BEQ;
                2:       code = CB_BR_J;
                default: code = 4'($urandom);
            endcase
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), $urandom, code, 1'($urandom));
        end
        check("final_addr", imem_addr, m_pc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
